uart_rx: RTL and testbench

- 8N1 UART receiver: oversamples the asynchronous serial line with the system clock, detects and validates the start bit, samples 8 data bits LSB-first at mid-bit, and checks the stop bit.
- Presents each received byte on a valid/ready handshake and flags framing and overrun errors.
- Sits between the board RX pin and byte-oriented consumers (command parsers, FIFOs); it is the receive-side counterpart of the team's `uart_tx`.

---
 rtl/uart_rx_pkg.sv | 12 +
 rtl/uart_rx_if.sv | 29 ++
 rtl/uart_rx_sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART frame constants and baud-rate derivation (used by uart_rx and uart_tx).
package uart_rx_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // System clocks per serial bit; integer divide, the caller guarantees >= 4.
    function automatic int clocks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte handshake from the UART receiver to its consumer, plus error pulses.
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic [DATA_BITS-1:0] rx_data_o;
    logic                 rx_valid_o;
    logic                 rx_ready_i;
    logic                 frame_err_o;
    logic                 overrun_o;

    // Receiver side: produces bytes and error pulses, observes ready.
    modport master (
        output rx_data_o,
        output rx_valid_o,
        output frame_err_o,
        output overrun_o,
        input  rx_ready_i
    );

    // Consumer side.
    modport slave (
        input  rx_data_o,
        input  rx_valid_o,
        input  frame_err_o,
        input  overrun_o,
        output rx_ready_i
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: double-flop synchronizer for asynchronous inputs, resets to all ones
// so an idle-high line does not look like activity coming out of reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            meta_r <= {WIDTH{1'b1}};
            sync_r <= {WIDTH{1'b1}};
        end else begin
            meta_r <= d_i;
            sync_r <= meta_r;
        end
    end

    assign q_o = sync_r;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver. Oversamples the synchronized line, validates the start
// bit at mid-bit, samples data LSB first, checks the stop bit and hands each byte
// out on a valid/ready handshake with framing and overrun pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic     clk_i,
    input  logic     reset_n_i,
    input  logic     rx_i,
    uart_rx_if.master rx_bus
);

    localparam int CPB     = clocks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF    = CPB / 2;
    localparam int CW      = ($clog2(CPB) < 1) ? 1 : $clog2(CPB);
    localparam int IW      = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    logic                 rx_s;
    state_t               state_r;
    logic [CW-1:0]        cnt_r;
    logic [IW-1:0]        idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 frame_err_r;
    logic                 overrun_r;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .d_i       (rx_i),
        .q_o       (rx_s)
    );

    // Frame FSM with bit timing, byte assembly and the output handshake.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            idx_r       <= {IW{1'b0}};
            shift_r     <= {DATA_BITS{1'b0}};
            data_r      <= {DATA_BITS{1'b0}};
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            // A transfer clears valid unless a commit below reloads it.
            if (valid_r && rx_bus.rx_ready_i) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end

            case (state_r)
                ST_IDLE: begin
                    cnt_r <= {CW{1'b0}};
                    if (!rx_s) begin
                        state_r <= ST_START;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (cnt_r == CW'(HALF - 1)) begin
                        cnt_r <= {CW{1'b0}};
                        idx_r <= {IW{1'b0}};
                        // Line back high at mid-start means a glitch, not a frame.
                        if (!rx_s) begin
                            state_r <= ST_DATA;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_r == CW'(CPB - 1)) begin
                        cnt_r          <= {CW{1'b0}};
                        shift_r[idx_r] <= rx_s;
                        if (idx_r == IW'(DATA_BITS - 1)) begin
                            state_r <= ST_STOP;
                        end else begin
                            idx_r <= idx_r + IW'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_r == CW'(CPB - 1)) begin
                        cnt_r <= {CW{1'b0}};
                        if (rx_s) begin
                            // Leave at mid-stop so a back-to-back start edge is not missed.
                            state_r <= ST_IDLE;
                            if (!valid_r || rx_bus.rx_ready_i) begin
                                data_r  <= shift_r;
                                valid_r <= 1'b1;
                            end else begin
                                overrun_r <= 1'b1;
                            end
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    // Hold off during a break so it is not read as a run of 0x00 bytes.
                    cnt_r <= {CW{1'b0}};
                    if (rx_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_HIGH;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign rx_bus.rx_data_o   = data_r;
    assign rx_bus.rx_valid_o  = valid_r;
    assign rx_bus.frame_err_o = frame_err_r;
    assign rx_bus.overrun_o   = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames, with an
// expected-byte queue and event counters as the reference model.
module tb_uart_rx;

    localparam int CPB = 10;

    logic clk;
    logic reset_n;
    logic rx;

    uart_rx_if bus ();

    uart_rx #(
        .CLOCK_FREQ (1_000_000),
        .BAUD_RATE  (100_000)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .rx_i      (rx),
        .rx_bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int cyc       = 0;
    int xfer_cnt  = 0;
    int ferr_cnt  = 0;
    int ovr_cnt   = 0;
    int vcyc_cnt  = 0;
    int rise_cyc  = 0;
    int start_cyc = 0;
    logic prev_valid = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: count events and score every handshake transfer against the queue.
    always @(negedge clk) begin
        logic [7:0] e;
        if (bus.rx_valid_o) vcyc_cnt++;
        if (bus.rx_valid_o && !prev_valid) rise_cyc = cyc;
        prev_valid = bus.rx_valid_o;
        if (bus.frame_err_o) ferr_cnt++;
        if (bus.overrun_o) ovr_cnt++;
        if (bus.rx_valid_o && bus.rx_ready_i) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                check_value("unexpected_byte", 32'(bus.rx_data_o), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_value("byte", 32'(bus.rx_data_o), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop_lvl;
        repeat (CPB) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_data"},  32'(bus.rx_data_o),   32'h0);
        check_value({tag, "_valid"}, 32'(bus.rx_valid_o),  32'h0);
        check_value({tag, "_ferr"},  32'(bus.frame_err_o), 32'h0);
        check_value({tag, "_ovr"},   32'(bus.overrun_o),   32'h0);
    endtask

    initial begin
        int x0, f0, o0, v0, lat, gap;
        logic [7:0] b;
        logic [7:0] b96;

        rx = 1'b1;
        reset_n = 1'b0;
        bus.rx_ready_i = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2 * CPB) tick();

        // Single byte with ready held high, plus latency and one-cycle valid.
        x0 = xfer_cnt; f0 = ferr_cnt; o0 = ovr_cnt; v0 = vcyc_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        repeat (2 * CPB) tick();
        lat = rise_cyc - start_cyc;
        check_value("a5_count", 32'(xfer_cnt - x0), 32'd1);
        check_value("a5_valid_cycles", 32'(vcyc_cnt - v0), 32'd1);
        check_value("a5_no_err", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'd0);
        check_value("a5_latency_in_range", 32'((lat >= 96) && (lat <= 98)), 32'd1);

        // Back-to-back frames with no idle gap.
        x0 = xfer_cnt; v0 = vcyc_cnt;
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        repeat (2 * CPB) tick();
        check_value("b2b_count", 32'(xfer_cnt - x0), 32'd3);
        check_value("b2b_valid_cycles", 32'(vcyc_cnt - v0), 32'd3);

        // Short low glitch on an idle line.
        x0 = xfer_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (3 * CPB) tick();
        check_value("glitch_no_byte", 32'(xfer_cnt - x0), 32'd0);
        check_value("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Framing error followed by a long break, then a good frame.
        x0 = xfer_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (30 * CPB) tick();
        rx = 1'b1;
        repeat (2 * CPB) tick();
        check_value("ferr_one_pulse", 32'(ferr_cnt - f0), 32'd1);
        check_value("ferr_no_byte", 32'(xfer_cnt - x0), 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        repeat (2 * CPB) tick();
        check_value("after_ferr_count", 32'(xfer_cnt - x0), 32'd1);

        // Overrun: consumer stalled across two frames; the second byte is lost.
        x0 = xfer_cnt; o0 = ovr_cnt;
        bus.rx_ready_i = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (2 * CPB) tick();
        check_value("ovr_one_pulse", 32'(ovr_cnt - o0), 32'd1);
        check_value("ovr_valid_held", 32'(bus.rx_valid_o), 32'd1);
        check_value("ovr_data_held", 32'(bus.rx_data_o), 32'h11);
        bus.rx_ready_i = 1'b1;
        repeat (3) tick();
        check_value("ovr_accept_count", 32'(xfer_cnt - x0), 32'd1);
        check_value("ovr_valid_cleared", 32'(bus.rx_valid_o), 32'd0);

        // Reset during data bit 4 of 0x96 aborts it; only 0x69 comes out.
        x0 = xfer_cnt; f0 = ferr_cnt;
        b96 = 8'h96;
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            rx = b96[i];
            repeat (CPB) tick();
        end
        rx = b96[4];
        repeat (CPB / 2) tick();
        reset_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("midreset");
        rx = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2 * CPB) tick();
        exp_q.push_back(8'h69);
        send_frame(8'h69, 1'b1);
        repeat (2 * CPB) tick();
        check_value("midreset_count", 32'(xfer_cnt - x0), 32'd1);
        check_value("midreset_no_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Random bytes with random idle gaps (including none), ready high.
        x0 = xfer_cnt; v0 = vcyc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        for (int n = 0; n < 20; n++) begin
            b = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 3);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            repeat (gap * CPB) tick();
        end
        repeat (2 * CPB) tick();
        check_value("rand_count", 32'(xfer_cnt - x0), 32'd20);
        check_value("rand_valid_cycles", 32'(vcyc_cnt - v0), 32'd20);
        check_value("rand_no_err", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'd0);

        check_value("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
